// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle two's-complement adder/subtractor.
// A WIDTH-bit operand pair is processed DIGIT bits per clock, LSB digit
// first, under a start/busy/done handshake. Reports sum/difference,
// carry-out of the MSB and signed overflow.
module serial_add_sub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             m,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [KW-1:0] KLAST = KW'(NDIG - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [KW-1:0]    k;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;      // b already conditioned by the mode (b ^ {m})
   logic [WIDTH-1:0] acc;      // partial result, filled one digit per cycle
   logic             carry;

   logic [DIGIT-1:0] a_d;
   logic [DIGIT-1:0] b_d;
   logic [DIGIT-1:0] d_sum;
   logic             d_cout;
   logic             msb_cin;
   logic             last;
   logic [WIDTH-1:0] acc_nxt;

   // One DIGIT-wide ripple step: returns {carry_out, sum}.
   function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x,
                                                input logic [DIGIT-1:0] y,
                                                input logic             ci);
      return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
   endfunction

   // Current digit selection, digit adder and merged result word.
   always_comb begin
      a_d              = a_q[k*DIGIT +: DIGIT];
      b_d              = b_q[k*DIGIT +: DIGIT];
      {d_cout, d_sum}  = digit_add(a_d, b_d, carry);
      // Carry into the top bit recovered from its sum bit and operand bits.
      msb_cin          = d_sum[DIGIT-1] ^ a_d[DIGIT-1] ^ b_d[DIGIT-1];
      last             = (k == KLAST);
      acc_nxt          = acc;
      acc_nxt[k*DIGIT +: DIGIT] = d_sum;
   end

   // Control FSM and registered outputs; reset aborts any operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         k     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         s     <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  k     <= '0;
               end
            end
            RUN: begin
               k <= k + 1'b1;
               if (last) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  s     <= acc_nxt;
                  cout  <= d_cout;
                  ovf   <= msb_cin ^ d_cout;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Operand capture and per-digit datapath state (not reset).
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         a_q   <= a;
         b_q   <= b ^ {WIDTH{m}};
         carry <= m;
      end else if (state == RUN) begin
         acc   <= acc_nxt;
         carry <= d_cout;
      end
   end

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: WIDTH=8 with DIGIT 1/2/4/8 plus WIDTH=4/DIGIT=1,
// all driven in parallel and compared against an integer reference model.
module tb_serial_add_sub;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       m;
   logic [7:0] a;
   logic [7:0] b;

   logic [4:0] busy_v;
   logic [4:0] done_v;
   logic [4:0] cout_v;
   logic [4:0] ovf_v;
   logic [7:0] s_v [4];
   logic [3:0] s4;

   int checks;
   int failures;
   int nd [5] = '{8, 4, 2, 1, 4};

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 4; gi++) begin : g_w8
      serial_add_sub #(.WIDTH(8), .DIGIT(1 << gi)) u_dut (
         .clk   (clk),
         .rst   (rst),
         .start (start),
         .m     (m),
         .a     (a),
         .b     (b),
         .busy  (busy_v[gi]),
         .done  (done_v[gi]),
         .s     (s_v[gi]),
         .cout  (cout_v[gi]),
         .ovf   (ovf_v[gi])
      );
   end

   serial_add_sub #(.WIDTH(4), .DIGIT(1)) u_dut_w4 (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .m     (m),
      .a     (a[3:0]),
      .b     (b[3:0]),
      .busy  (busy_v[4]),
      .done  (done_v[4]),
      .s     (s4),
      .cout  (cout_v[4]),
      .ovf   (ovf_v[4])
   );

   function automatic logic [7:0] get_s(input int i);
      if (i == 4) return {4'h0, s4};
      return s_v[i];
   endfunction

   // Reference: plain integer arithmetic on unsigned and signed views.
   // Returns {cout, ovf, s[7:0]}.
   function automatic logic [9:0] ref_model(input logic mm, input int ua, input int ub, input int w);
      int full, half, sa, sb, r, sres;
      logic c, o;
      full = 1 << w;
      half = 1 << (w - 1);
      sa   = (ua >= half) ? ua - full : ua;
      sb   = (ub >= half) ? ub - full : ub;
      r    = mm ? (sa - sb) : (sa + sb);
      o    = (r < -half) || (r >= half);
      c    = mm ? (ua >= ub) : ((ua + ub) >= full);
      sres = (mm ? (ua - ub) : (ua + ub)) & (full - 1);
      return {c, o, 8'(sres)};
   endfunction

   task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
      end
   endtask

   // Issue one operation on all instances and check result, latency,
   // single done pulse and busy/done exclusivity. With wig set, a second
   // start (0xAA/0x55) is pulsed one cycle later and inputs churn each cycle.
   task automatic do_op(input logic mm, input logic [7:0] aa, input logic [7:0] bb, input bit wig);
      int         lat [5];
      int         cnt [5];
      int         ovl [5];
      logic [7:0] cs  [5];
      logic       cc  [5];
      logic       co  [5];
      logic [9:0] r;
      int         w, ua, ub;
      @(negedge clk);
      start = 1'b1; m = mm; a = aa; b = bb;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         chk("busy_at_start", i, 32'(busy_v[i]), 32'd1);
         lat[i] = -1; cnt[i] = 0; ovl[i] = 0;
         cs[i] = 8'h00; cc[i] = 1'b0; co[i] = 1'b0;
      end
      for (int cyc = 1; cyc <= 11; cyc++) begin
         @(negedge clk);
         if (wig) begin
            start = (cyc == 1);
            if (cyc == 1) begin
               a = 8'hAA; b = 8'h55;
            end else begin
               a = 8'($urandom); b = 8'($urandom);
            end
            m = 1'($urandom);
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         for (int i = 0; i < 5; i++) begin
            if (busy_v[i] && done_v[i]) ovl[i]++;
            if (done_v[i]) begin
               cnt[i]++;
               lat[i] = cyc;
               cs[i]  = get_s(i);
               cc[i]  = cout_v[i];
               co[i]  = ovf_v[i];
            end
         end
      end
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         w  = (i == 4) ? 4 : 8;
         ua = int'(aa) & ((1 << w) - 1);
         ub = int'(bb) & ((1 << w) - 1);
         r  = ref_model(mm, ua, ub, w);
         chk("done_pulses", i, 32'(cnt[i]), 32'd1);
         chk("latency", i, 32'(lat[i]), 32'(nd[i]));
         chk("busy_done_overlap", i, 32'(ovl[i]), 32'd0);
         chk("s", i, 32'(cs[i]), 32'(r[7:0]));
         chk("cout", i, 32'(cc[i]), 32'(r[9]));
         chk("ovf", i, 32'(co[i]), 32'(r[8]));
      end
   endtask

   initial begin
      int dn;
      checks = 0; failures = 0;
      rst = 1'b1; start = 1'b0; m = 1'b0; a = 8'h00; b = 8'h00;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("rst_s", i, 32'(get_s(i)), 32'd0);
         chk("rst_cout", i, 32'(cout_v[i]), 32'd0);
         chk("rst_ovf", i, 32'(ovf_v[i]), 32'd0);
         chk("rst_busy", i, 32'(busy_v[i]), 32'd0);
         chk("rst_done", i, 32'(done_v[i]), 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      // Add and subtract directed cases
      do_op(1'b0, 8'h03, 8'h00, 1'b0);
      do_op(1'b0, 8'hFF, 8'hFF, 1'b0);
      do_op(1'b0, 8'h7F, 8'h01, 1'b0);
      do_op(1'b1, 8'h08, 8'h02, 1'b0);
      do_op(1'b1, 8'h02, 8'h05, 1'b0);
      do_op(1'b1, 8'h80, 8'h01, 1'b0);
      chk("sub_borrow_s_dig2", 1, 32'(s_v[1]), 32'h7F);

      // Second start during RUN is ignored; inputs churn after capture
      do_op(1'b0, 8'h10, 8'h01, 1'b1);
      chk("handshake_s_dig2", 1, 32'(s_v[1]), 32'h11);

      // Reset mid-operation at E2
      @(negedge clk);
      start = 1'b1; m = 1'b0; a = 8'h0F; b = 8'h01;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         chk("midrst_busy", i, 32'(busy_v[i]), 32'd0);
         chk("midrst_done", i, 32'(done_v[i]), 32'd0);
         chk("midrst_s", i, 32'(get_s(i)), 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(posedge clk); #1;
         if (done_v != 5'b0) dn++;
      end
      chk("midrst_no_done", 0, 32'(dn), 32'd0);
      do_op(1'b0, 8'h0F, 8'h01, 1'b0);

      // Random operands
      repeat (30) do_op(1'($urandom), 8'($urandom), 8'($urandom), 1'b0);

      // Exhaustive 4-bit sweep
      for (int mm = 0; mm < 2; mm++)
         for (int aa = 0; aa < 16; aa++)
            for (int bb = 0; bb < 16; bb++)
               do_op(1'(mm), 8'(aa), 8'(bb), 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
